if_id_skid_stage: RTL and testbench
===================================

Name: if_id_skid_stage

Overview:
- Parametrised IF/ID pipeline stage register for the 5-stage CPU. Replaces the half-cycle latch with a fully synchronous, valid/ready handshaked 2-entry skid stage.
- Carries instruction and PC from fetch to decode.
- Supports decode back-pressure (stall), branch flush and NOP bubble injection without dropping or duplicating instructions.
- Also counts stall cycles for performance measurement.

Parameters:
- INSTR_W, 32, instruction width in bits.
- PC_W, 32, program counter width in bits.
- NOP_INSTR, 32'h0000_0000, value driven on out_instr when no valid instruction is present (MIPS sll $0,$0,0). Width INSTR_W.
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge only.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents a valid instruction.
- in_ready  out  1  stage can accept; registered, never combinationally dependent on out_ready.
- in_instr  in  INSTR_W  fetched instruction.
- in_pc  in  PC_W  PC of fetched instruction.
- flush  in  1  squash all held and incoming instructions (branch taken / jump).
- out_valid  out  1  out_instr/out_pc hold a valid instruction.
- out_ready  in  1  decode consumes this cycle (deasserted = stall).
- out_instr  out  INSTR_W  instruction to decode; NOP_INSTR when out_valid=0.
- out_pc  out  PC_W  PC to decode; 0 when out_valid=0.
- stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- clr_cnt  in  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=EMPTY; in_ready=1; out_valid=0.
  - out_instr=NOP_INSTR; out_pc=0; stall_cnt=0; skid register cleared.
- Storage: main register (drives outputs) and skid register (one overflow entry).
- Events: accept = in_valid & in_ready; consume = out_valid & out_ready.
- States and transitions (no flush):
  - EMPTY: accept -> ONE, main<=input; else stay.
  - ONE:
    - accept & consume -> ONE, main<=input.
    - accept & !consume -> FULL, skid<=input.
    - !accept & consume -> EMPTY.
    - else stay.
  - FULL (in_ready=0, so accept impossible): consume -> ONE, main<=skid; else stay.
- in_ready = (state != FULL), registered from next-state.
- Latency: an accepted instruction appears on outputs the next cycle when the stage was EMPTY, or when ONE with simultaneous consume.
- Throughput: 1 instr/cycle when out_ready is held 1.
- Ordering is strictly FIFO: no drop, no duplicate.
- Flush (highest priority over all other events):
  - Next state EMPTY; in_ready=1 next cycle; out_valid=0 next cycle.
  - out_instr<=NOP_INSTR; out_pc<=0.
  - An instruction accepted in the flush cycle is discarded.
  - A consume in the flush cycle is still a legal transfer to decode; the stage does not undo it.
- stall_cnt:
  - Increments when out_valid & !out_ready & !flush & !clr_cnt.
  - Saturates at all-ones.
  - clr_cnt has priority over increment.
  - flush does not clear it; reset does.
- Outputs out_instr/out_pc change only when main is loaded or the stage goes EMPTY. They are stable while stalled.
- Reset asserted mid-operation: all held instructions are lost; outputs go to reset values immediately (asynchronously).
- Widths: no arithmetic on data paths; stall_cnt compare against {STALL_CNT_W{1'b1}} for saturation.

Decomposition:
- Shared package (pipeline pkg):
  - State encoding constants: EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
  - Default NOP_INSTR constant.
  - A pipeline-payload typedef {pc, instr}, reused by the ID/EX and EX/MEM successors.
- One natural sub-module, sat_counter (parametrised width, inc, clr), reused for other performance counters.
- The skid datapath stays inline.

Test Plan:
- Reset check: hold rst_n=0, then release -> in_ready=1, out_valid=0, out_instr=32'h0, out_pc=0, stall_cnt=0.
- Streaming: out_ready=1; feed instr 0x20080005/pc 0x0, 0x20090003/pc 0x4, 0x01095020/pc 0x8 on consecutive cycles -> each appears 1 cycle later, in order, out_valid=1 continuously, in_ready never drops.
- Stall/skid:
  - Stimulus: out_ready=0 after first instr (pc 0x0) arrives; keep in_valid=1 with pc 0x4, 0x8.
  - Response: pc 0x4 goes to skid, in_ready=0 next cycle; stall_cnt counts 1,2,3 while stalled.
  - Release out_ready=1 -> outputs pc 0x0, 0x4, 0x8 in order, no loss.
- Flush while FULL: assert flush with in_valid=1 (pc 0xC) -> next cycle out_valid=0, out_instr=NOP_INSTR, out_pc=0, in_ready=1; pc 0xC never appears at the output.
- Counter saturation: STALL_CNT_W=4, stall 20 cycles -> stall_cnt stops at 15; pulse clr_cnt during the stall -> 0 that cycle edge, then increments again.
- Async reset mid-stream: drop rst_n between clock edges while FULL -> out_valid=0 and in_ready=1 immediately, before the next clk edge.

Source files
------------

// File: rtl/if_id_skid_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_id_skid_stage_pkg
//   Shared definitions for the pipeline stage registers of the 5-stage CPU
//   (IF/ID today, ID/EX and EX/MEM successors reuse the payload and state
//   encoding).
//   Contents:
//     skid_state_e     - occupancy of a 2-entry skid stage
//     NOP_INSTR_DEFAULT- bubble instruction (MIPS sll $0,$0,0)
//     pipe_payload_t   - {pc, instr} pair carried between stages
//     state_accepts()  - whether a stage in a given state can take input
// ---------------------------------------------------------------------------
package if_id_skid_stage_pkg;

  // Occupancy of the stage: nothing held, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam int unsigned PIPE_INSTR_W = 32;
  localparam int unsigned PIPE_PC_W    = 32;

  localparam logic [PIPE_INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Default-width payload moved between pipeline stages.
  typedef struct packed {
    logic [PIPE_PC_W-1:0]    pc;
    logic [PIPE_INSTR_W-1:0] instr;
  } pipe_payload_t;

  // A stage can take a new entry unless both of its slots are occupied.
  function automatic logic state_accepts(input skid_state_e s);
    return (s != FULL);
  endfunction

endpackage

// File: rtl/if_id_skid_stage_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter for performance measurement.
//   Ports:
//     clk    in   clock
//     rst_n  in   asynchronous active-low reset (count -> 0)
//     inc    in   count one event this cycle
//     clr    in   synchronous clear, wins over inc
//     count  out  current value, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;

  // Counter register: clear first, then saturating increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= CNT_ZERO;
    end else if (clr) begin
      r_count <= CNT_ZERO;
    end else if (inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/if_id_skid_stage.sv
// ---------------------------------------------------------------------------
// if_id_skid_stage
//   IF/ID pipeline register built as a 2-entry valid/ready skid stage.
//   The main register drives decode; the skid register absorbs the one
//   instruction that fetch may push while decode is stalled, so in_ready
//   can be a pure register output with no path from out_ready.
//   Ports:
//     clk        in   clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   fetch presents an instruction
//     in_ready   out  stage accepts this cycle (registered)
//     in_instr   in   fetched instruction
//     in_pc      in   PC of fetched instruction
//     flush      in   squash everything held and incoming
//     out_valid  out  out_instr/out_pc are valid
//     out_ready  in   decode consumes this cycle
//     out_instr  out  instruction to decode, NOP_INSTR when invalid
//     out_pc     out  PC to decode, 0 when invalid
//     stall_cnt  out  saturating count of stalled valid cycles
//     clr_cnt    in   synchronous clear of stall_cnt
// ---------------------------------------------------------------------------
module if_id_skid_stage
  import if_id_skid_stage_pkg::*;
#(
  parameter int unsigned       INSTR_W     = 32,
  parameter int unsigned       PC_W        = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR  = INSTR_W'(NOP_INSTR_DEFAULT),
  parameter int unsigned       STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_W-1:0]     in_instr,
  input  logic [PC_W-1:0]        in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [PC_W-1:0]        out_pc,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  input  logic                   clr_cnt
);

  localparam logic [PC_W-1:0]    PC_ZERO    = {PC_W{1'b0}};
  localparam logic [INSTR_W-1:0] INSTR_ZERO = {INSTR_W{1'b0}};

  skid_state_e        r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [INSTR_W-1:0] r_main_instr;
  logic [PC_W-1:0]    r_main_pc;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [PC_W-1:0]    r_skid_pc;

  logic w_accept;
  logic w_consume;
  logic w_stall_inc;

  assign w_accept    = in_valid & r_in_ready;
  assign w_consume   = r_out_valid & out_ready;
  // A flush cycle is not counted as a stall even if decode held off.
  assign w_stall_inc = r_out_valid & ~out_ready & ~flush;

  // Occupancy FSM with main/skid datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= EMPTY;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_main_instr <= NOP_INSTR;
      r_main_pc    <= PC_ZERO;
      r_skid_instr <= INSTR_ZERO;
      r_skid_pc    <= PC_ZERO;
    end else if (flush) begin
      // Anything held or accepted this cycle is dropped; a consume in the
      // same cycle already reached decode and stands.
      r_state      <= EMPTY;
      r_in_ready   <= state_accepts(EMPTY);
      r_out_valid  <= 1'b0;
      r_main_instr <= NOP_INSTR;
      r_main_pc    <= PC_ZERO;
      r_skid_instr <= INSTR_ZERO;
      r_skid_pc    <= PC_ZERO;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_state      <= ONE;
            r_in_ready   <= state_accepts(ONE);
            r_out_valid  <= 1'b1;
            r_main_instr <= in_instr;
            r_main_pc    <= in_pc;
          end else begin
            r_state    <= EMPTY;
            r_in_ready <= state_accepts(EMPTY);
          end
        end
        ONE: begin
          if (w_accept && w_consume) begin
            // Pass-through: new instruction replaces the one decode took.
            r_state      <= ONE;
            r_in_ready   <= state_accepts(ONE);
            r_main_instr <= in_instr;
            r_main_pc    <= in_pc;
          end else if (w_accept) begin
            // Decode stalled: park the new instruction behind main.
            r_state      <= FULL;
            r_in_ready   <= state_accepts(FULL);
            r_skid_instr <= in_instr;
            r_skid_pc    <= in_pc;
          end else if (w_consume) begin
            r_state      <= EMPTY;
            r_in_ready   <= state_accepts(EMPTY);
            r_out_valid  <= 1'b0;
            r_main_instr <= NOP_INSTR;
            r_main_pc    <= PC_ZERO;
          end else begin
            r_state    <= ONE;
            r_in_ready <= state_accepts(ONE);
          end
        end
        FULL: begin
          // in_ready is low here, so only decode can make progress.
          if (w_consume) begin
            r_state      <= ONE;
            r_in_ready   <= state_accepts(ONE);
            r_main_instr <= r_skid_instr;
            r_main_pc    <= r_skid_pc;
          end else begin
            r_state    <= FULL;
            r_in_ready <= state_accepts(FULL);
          end
        end
        default: begin
          r_state      <= EMPTY;
          r_in_ready   <= 1'b1;
          r_out_valid  <= 1'b0;
          r_main_instr <= NOP_INSTR;
          r_main_pc    <= PC_ZERO;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .clr   (clr_cnt),
    .count (stall_cnt)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_instr = r_main_instr;
  assign out_pc    = r_main_pc;

endmodule

// File: tb/tb_if_id_skid_stage.sv
module tb_if_id_skid_stage;

  localparam int          CW     = 4;
  localparam int          CNT_MX = (1 << CW) - 1;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_instr = 32'h0;
  logic [31:0]   in_pc = 32'h0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [CW-1:0] stall_cnt;
  logic          clr_cnt = 1'b0;

  always #5 clk = ~clk;

  if_id_skid_stage #(
    .INSTR_W     (32),
    .PC_W        (32),
    .NOP_INSTR   (NOP),
    .STALL_CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .stall_cnt (stall_cnt),
    .clr_cnt   (clr_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two entries plus a stall counter.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  bit          m_in_ready = 1'b1;
  int          m_cnt = 0;
  logic [31:0] consumed[$];
  bit          cmp_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_in_ready = 1'b1;
      m_cnt = 0;
    end else begin
      bit acc;
      bit con;
      acc = in_valid && m_in_ready;
      con = (mq.size() > 0) && out_ready;
      if (out_valid && out_ready) consumed.push_back(out_pc);
      if (clr_cnt) m_cnt = 0;
      else if ((mq.size() > 0) && !out_ready && !flush && (m_cnt < CNT_MX)) m_cnt++;
      if (flush) begin
        mq.delete();
      end else begin
        if (con) void'(mq.pop_front());
        if (acc) mq.push_back('{in_instr, in_pc});
      end
      m_in_ready = (mq.size() < 2);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mdl_out_valid", {63'd0, out_valid}, {63'd0, (mq.size() > 0)});
      chk("mdl_out_instr", {32'd0, out_instr}, {32'd0, (mq.size() > 0) ? mq[0].instr : NOP});
      chk("mdl_out_pc",    {32'd0, out_pc},    {32'd0, (mq.size() > 0) ? mq[0].pc : 32'h0});
      chk("mdl_in_ready",  {63'd0, in_ready},  {63'd0, m_in_ready});
      chk("mdl_stall_cnt", {60'd0, stall_cnt}, 64'(m_cnt));
    end
  end

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl, input bit clr);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    clr_cnt   = clr;
    @(negedge clk);
  endtask

  localparam logic [31:0] IA = 32'h2008_0005;
  localparam logic [31:0] IB = 32'h2009_0003;
  localparam logic [31:0] IC = 32'h0109_5020;

  initial begin
    logic [31:0] exp_pcs[$];

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rel_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rel_out_instr", {32'd0, out_instr}, 64'h0);
    chk("rel_out_pc", {32'd0, out_pc}, 64'h0);
    chk("rel_stall_cnt", {60'd0, stall_cnt}, 64'd0);

    // Streaming at full throughput
    drive(1'b1, IA, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("str0_valid", {63'd0, out_valid}, 64'd1);
    chk("str0_pc", {32'd0, out_pc}, 64'h0);
    chk("str0_instr", {32'd0, out_instr}, 64'h2008_0005);
    drive(1'b1, IB, 32'h4, 1'b1, 1'b0, 1'b0);
    chk("str1_pc", {32'd0, out_pc}, 64'h4);
    chk("str1_instr", {32'd0, out_instr}, 64'h2009_0003);
    chk("str1_in_ready", {63'd0, in_ready}, 64'd1);
    drive(1'b1, IC, 32'h8, 1'b1, 1'b0, 1'b0);
    chk("str2_pc", {32'd0, out_pc}, 64'h8);
    chk("str2_instr", {32'd0, out_instr}, 64'h0109_5020);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("str_drain_valid", {63'd0, out_valid}, 64'd0);

    // Stall with skid
    drive(1'b1, IA, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("stl_first_pc", {32'd0, out_pc}, 64'h0);
    drive(1'b1, IB, 32'h4, 1'b0, 1'b0, 1'b0);
    chk("stl_in_ready", {63'd0, in_ready}, 64'd0);
    chk("stl_cnt1", {60'd0, stall_cnt}, 64'd1);
    chk("stl_hold_pc", {32'd0, out_pc}, 64'h0);
    drive(1'b1, IC, 32'h8, 1'b0, 1'b0, 1'b0);
    chk("stl_cnt2", {60'd0, stall_cnt}, 64'd2);
    drive(1'b1, IC, 32'h8, 1'b0, 1'b0, 1'b0);
    chk("stl_cnt3", {60'd0, stall_cnt}, 64'd3);
    chk("stl_hold_instr", {32'd0, out_instr}, 64'h2008_0005);
    drive(1'b1, IC, 32'h8, 1'b1, 1'b0, 1'b0);
    chk("rel_skid_pc", {32'd0, out_pc}, 64'h4);
    chk("rel_in_ready2", {63'd0, in_ready}, 64'd1);
    chk("rel_cnt_hold", {60'd0, stall_cnt}, 64'd3);
    drive(1'b1, IC, 32'h8, 1'b1, 1'b0, 1'b0);
    chk("rel_last_pc", {32'd0, out_pc}, 64'h8);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("rel_drain_valid", {63'd0, out_valid}, 64'd0);

    // Flush while FULL, with an incoming instruction
    drive(1'b1, 32'h1111_1111, 32'h10, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h2222_2222, 32'h14, 1'b0, 1'b0, 1'b0);
    chk("fl_full_in_ready", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 32'h3333_3333, 32'hC, 1'b0, 1'b1, 1'b0);
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_out_instr", {32'd0, out_instr}, 64'h0);
    chk("fl_out_pc", {32'd0, out_pc}, 64'h0);
    chk("fl_in_ready", {63'd0, in_ready}, 64'd1);
    chk("fl_cnt_kept", {60'd0, stall_cnt}, 64'd4);
    repeat (3) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("fl_after_valid", {63'd0, out_valid}, 64'd0);

    // Counter saturation and clear during stall
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("sat_clr0", {60'd0, stall_cnt}, 64'd0);
    drive(1'b1, 32'h4444_4444, 32'h20, 1'b0, 1'b0, 1'b0);
    chk("sat_start", {60'd0, stall_cnt}, 64'd0);
    repeat (20) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("sat_max", {60'd0, stall_cnt}, 64'd15);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("sat_clr", {60'd0, stall_cnt}, 64'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("sat_reinc", {60'd0, stall_cnt}, 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("sat_drain_valid", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset while FULL
    drive(1'b1, 32'h5555_5555, 32'h30, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h6666_6666, 32'h34, 1'b0, 1'b0, 1'b0);
    chk("ar_full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("ar_cnt_before", {60'd0, stall_cnt}, 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", {63'd0, out_valid}, 64'd0);
    chk("ar_in_ready", {63'd0, in_ready}, 64'd1);
    chk("ar_out_pc", {32'd0, out_pc}, 64'h0);
    chk("ar_out_instr", {32'd0, out_instr}, 64'h0);
    chk("ar_stall_cnt", {60'd0, stall_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("ar_after_valid", {63'd0, out_valid}, 64'd0);

    // Everything decode received, in order
    cmp_en = 1'b0;
    exp_pcs = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8, 32'h20};
    chk("ord_count", 64'(consumed.size()), 64'(exp_pcs.size()));
    for (int i = 0; i < exp_pcs.size(); i++) begin
      chk($sformatf("ord_pc%0d", i),
          {32'd0, (i < consumed.size()) ? consumed[i] : 32'hFFFF_FFFF},
          {32'd0, exp_pcs[i]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
